// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - 16-bit memory bus sequencer serialising over the 8-bit Arduino byte bus
// Optional handshake timeout with sticky bus_err: define MEM_BUS_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_bus_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic        ard_data_ready,
    input  logic        ard_receive_ready,
    input  logic [7:0]  in_bus,
    output logic [7:0]  out_bus,
    output logic        bus_strobe,
    output logic        bus_pc,
    output logic        bus_mar,
    output logic        bus_mdr,
    output logic        bus_we,
    output logic        fetch_done,
    output logic [15:0] fetch_data,
    output logic        mem_done,
    output logic [15:0] mem_rdata,
    output logic        busy
`ifdef MEM_BUS_TIMEOUT_EN
    ,
    output logic        bus_err
`endif
);
    typedef enum logic [2:0] {
        IDLE, ADDR_LO, ADDR_HI, WDATA_LO, WDATA_HI, RDATA_LO, RDATA_HI, DONE
    } state_e;

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("mem_bus_ctrl: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    state_e                 state_q, state_d;
    logic                   phase_q, phase_d;
    logic [15:0]            addr_q, addr_d;
    logic [15:0]            wdata_q, wdata_d;
    logic [15:0]            rdata_q, rdata_d;
    logic                   we_q, we_d;
    logic                   fetch_q, fetch_d;
    logic [SYNC_STAGES-1:0] sync_rx_q, sync_tx_q;
    logic                   rdy_rx_q, rdy_tx_q;
    logic                   is_tx, hs_rdy;
`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]          wait_q;
    logic                   abort;
`endif

    function automatic state_e next_byte(input state_e s, input logic we);
        case (s)
            ADDR_LO:  return ADDR_HI;
            ADDR_HI:  return we ? WDATA_LO : RDATA_LO;
            WDATA_LO: return WDATA_HI;
            RDATA_LO: return RDATA_HI;
            default:  return DONE;
        endcase
    endfunction

    // The last two stages must agree before the ready level changes, so a
    // pulse narrower than the synchroniser path never reaches the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_rx_q <= '0;
            sync_tx_q <= '0;
            rdy_rx_q  <= 1'b0;
            rdy_tx_q  <= 1'b0;
        end else begin
            sync_rx_q <= {sync_rx_q[SYNC_STAGES-2:0], ard_data_ready};
            sync_tx_q <= {sync_tx_q[SYNC_STAGES-2:0], ard_receive_ready};
            if (sync_rx_q[SYNC_STAGES-1] == sync_rx_q[SYNC_STAGES-2])
                rdy_rx_q <= sync_rx_q[SYNC_STAGES-1];
            if (sync_tx_q[SYNC_STAGES-1] == sync_tx_q[SYNC_STAGES-2])
                rdy_tx_q <= sync_tx_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        fetch_d = fetch_q;
        is_tx   = state_q inside {ADDR_LO, ADDR_HI, WDATA_LO, WDATA_HI};
        hs_rdy  = is_tx ? rdy_tx_q : rdy_rx_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    we_d    = mem_we;
                    fetch_d = 1'b0;
                    state_d = ADDR_LO;
                    phase_d = 1'b0;
                end else if (fetch_req) begin
                    addr_d  = fetch_addr;
                    we_d    = 1'b0;
                    fetch_d = 1'b1;
                    state_d = ADDR_LO;
                    phase_d = 1'b0;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                if (!phase_q) begin
                    if (hs_rdy) begin
                        phase_d = 1'b1;
                        if (state_q == RDATA_LO) rdata_d[7:0]  = in_bus;
                        if (state_q == RDATA_HI) rdata_d[15:8] = in_bus;
                    end
                end else if (!hs_rdy) begin
                    phase_d = 1'b0;
                    state_d = next_byte(state_q, we_q);
                end
            end
        endcase
`ifdef MEM_BUS_TIMEOUT_EN
        abort = (state_q != IDLE) && (state_d == state_q) && (phase_d == phase_q)
                && (wait_q == CW'(TIMEOUT_CYCLES - 1));
        if (abort) begin
            state_d = IDLE;
            phase_d = 1'b0;
        end
`endif
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            phase_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            we_q       <= 1'b0;
            fetch_q    <= 1'b0;
            out_bus    <= '0;
            bus_strobe <= 1'b0;
            bus_pc     <= 1'b0;
            bus_mar    <= 1'b0;
            bus_mdr    <= 1'b0;
            bus_we     <= 1'b0;
            fetch_done <= 1'b0;
            fetch_data <= '0;
            mem_done   <= 1'b0;
            mem_rdata  <= '0;
            busy       <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            wait_q     <= '0;
            bus_err    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            fetch_q <= fetch_d;
            case (state_d)
                ADDR_LO:  out_bus <= addr_d[7:0];
                ADDR_HI:  out_bus <= addr_d[15:8];
                WDATA_LO: out_bus <= wdata_d[7:0];
                WDATA_HI: out_bus <= wdata_d[15:8];
                default:  out_bus <= '0;
            endcase
            if (state_d inside {ADDR_LO, ADDR_HI, WDATA_LO, WDATA_HI})
                bus_strobe <= !phase_d;
            else if (state_d inside {RDATA_LO, RDATA_HI})
                bus_strobe <= phase_d;
            else
                bus_strobe <= 1'b0;
            bus_pc     <= (state_d inside {ADDR_LO, ADDR_HI}) && fetch_d;
            bus_mar    <= (state_d inside {ADDR_LO, ADDR_HI}) && !fetch_d;
            bus_mdr    <= state_d inside {WDATA_LO, WDATA_HI, RDATA_LO, RDATA_HI};
            bus_we     <= (state_d != IDLE) && we_d;
            busy       <= state_d != IDLE;
            fetch_done <= (state_d == DONE) && fetch_d;
            mem_done   <= (state_d == DONE) && !fetch_d;
            if (state_d == DONE && fetch_d)
                fetch_data <= rdata_d;
            if (state_d == DONE && !fetch_d && !we_d)
                mem_rdata <= rdata_d;
`ifdef MEM_BUS_TIMEOUT_EN
            if (state_q == IDLE || state_d != state_q || phase_d != phase_q)
                wait_q <= '0;
            else
                wait_q <= wait_q + 1'b1;
            if (abort)
                bus_err <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - randomized self-checking bench for mem_bus_ctrl with an Arduino memory model
`timescale 1ns/1ps
module tb_mem_bus_ctrl;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [15:0] fetch_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic        ard_data_ready, ard_receive_ready;
    logic [7:0]  in_bus;
    logic [7:0]  out_bus;
    logic        bus_strobe, bus_pc, bus_mar, bus_mdr, bus_we;
    logic        fetch_done, mem_done, busy;
    logic [15:0] fetch_data, mem_rdata;
`ifdef MEM_BUS_TIMEOUT_EN
    logic        bus_err;
`endif
    logic [47:0] all_outs;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .ard_data_ready(ard_data_ready), .ard_receive_ready(ard_receive_ready), .in_bus(in_bus),
        .out_bus(out_bus), .bus_strobe(bus_strobe), .bus_pc(bus_pc), .bus_mar(bus_mar),
        .bus_mdr(bus_mdr), .bus_we(bus_we),
        .fetch_done(fetch_done), .fetch_data(fetch_data),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_BUS_TIMEOUT_EN
        , .bus_err(bus_err)
`endif
    );

    assign all_outs = {out_bus, bus_strobe, bus_pc, bus_mar, bus_mdr, bus_we,
                       fetch_done, fetch_data, mem_done, mem_rdata, busy};

    int n_cmp = 0, n_fail = 0;
    int n_fdone = 0, n_mdone = 0;
    bit done_order[$];
    logic [11:0] tx_log[$];
    logic [15:0] ard_mem [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] exp_fdata = '0, exp_mrdata = '0;
    int  ard_delay = 3;
    bit  ard_en = 1'b1;
    bit  glitch_arm = 1'b0, glitch_held = 1'b0;

    function automatic logic [15:0] dflt(input logic [15:0] a);
        return a * 16'd7 + 16'h1357;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    always @(negedge clk) begin
        if (fetch_done) begin n_fdone++; done_order.push_back(1'b1); end
        if (mem_done)   begin n_mdone++; done_order.push_back(1'b0); end
    end

    // Arduino side: an external 64K-word memory speaking the 4-phase byte protocol.
    initial begin : arduino
        int a_cnt, d_cnt, r_cnt, k;
        logic [15:0] cur_addr, cur_wd, word;
        logic [7:0] last_b;
        a_cnt = 0; d_cnt = 0; r_cnt = 0; cur_addr = '0; cur_wd = '0;
        ard_data_ready = 1'b0; ard_receive_ready = 1'b0; in_bus = '0;
        forever begin
            @(negedge clk);
            if (!busy || !rst) begin a_cnt = 0; d_cnt = 0; r_cnt = 0; end
            if (!ard_en || !rst) begin
                ard_data_ready = 1'b0;
                ard_receive_ready = 1'b0;
            end else if (bus_strobe && !(bus_mdr && !bus_we)) begin
                last_b = out_bus;
                tx_log.push_back({bus_pc, bus_mar, bus_mdr, bus_we, out_bus});
                if (bus_pc || bus_mar) begin
                    if (a_cnt == 0) cur_addr[7:0] = out_bus; else cur_addr[15:8] = out_bus;
                    a_cnt++;
                end else begin
                    if (d_cnt == 0) cur_wd[7:0] = out_bus;
                    else begin cur_wd[15:8] = out_bus; ard_mem[cur_addr] = cur_wd; end
                    d_cnt++;
                end
                if (glitch_arm) begin
                    glitch_arm = 1'b0;
                    ard_receive_ready = 1'b1;
                    @(negedge clk);
                    ard_receive_ready = 1'b0;
                    glitch_held = 1'b1;
                    repeat (8) begin
                        @(negedge clk);
                        if (!bus_strobe || out_bus !== last_b) glitch_held = 1'b0;
                    end
                end
                repeat (ard_delay) @(negedge clk);
                ard_receive_ready = 1'b1;
                k = 0;
                while (bus_strobe && k < 5000) begin @(negedge clk); k++; end
                repeat (ard_delay) @(negedge clk);
                ard_receive_ready = 1'b0;
            end else if (busy && bus_mdr && !bus_we && !bus_strobe) begin
                word = ard_mem.exists(cur_addr) ? ard_mem[cur_addr] : dflt(cur_addr);
                in_bus = (r_cnt == 0) ? word[7:0] : word[15:8];
                r_cnt++;
                repeat (ard_delay) @(negedge clk);
                ard_data_ready = 1'b1;
                k = 0;
                while (rst && !bus_strobe && k < 5000) begin @(negedge clk); k++; end
                repeat (ard_delay) @(negedge clk);
                ard_data_ready = 1'b0;
                k = 0;
                while (rst && bus_strobe && k < 5000) begin @(negedge clk); k++; end
            end
        end
    end

    task automatic run_txn(input bit is_f, input bit we, input logic [15:0] a,
                           input logic [15:0] wd, input string tag);
        logic [11:0] exp_log[$];
        int fd0, md0, k;
        bit seen;
        fd0 = n_fdone; md0 = n_mdone;
        exp_log.push_back({is_f, !is_f, 1'b0, we, a[7:0]});
        exp_log.push_back({is_f, !is_f, 1'b0, we, a[15:8]});
        if (we) begin
            exp_log.push_back({3'b001, 1'b1, wd[7:0]});
            exp_log.push_back({3'b001, 1'b1, wd[15:8]});
            ref_mem[a] = wd;
        end else if (is_f) exp_fdata = ref_rd(a);
        else               exp_mrdata = ref_rd(a);
        @(negedge clk);
        tx_log.delete();
        if (is_f) begin fetch_req = 1'b1; fetch_addr = a; end
        else begin mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = wd; end
        k = 0; seen = 1'b0;
        while (!seen && k < 3000) begin
            @(negedge clk);
            seen = is_f ? fetch_done : mem_done;
            k++;
        end
        fetch_req = 1'b0; mem_req = 1'b0;
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s done_timeout: got no done pulse, required one within 3000 cycles", tag);
        end
        n_cmp++;
        if (is_f && fetch_data !== exp_fdata) begin
            n_fail++;
            $display("FAIL %s fetch_data: got %h required %h", tag, fetch_data, exp_fdata);
        end else if (!is_f && mem_rdata !== exp_mrdata) begin
            n_fail++;
            $display("FAIL %s mem_rdata: got %h required %h", tag, mem_rdata, exp_mrdata);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ((n_fdone - fd0) != (is_f ? 1 : 0) || (n_mdone - md0) != (is_f ? 0 : 1)) begin
            n_fail++;
            $display("FAIL %s done_count: got fetch=%0d mem=%0d required fetch=%0d mem=%0d",
                     tag, n_fdone - fd0, n_mdone - md0, is_f ? 1 : 0, is_f ? 0 : 1);
        end
        n_cmp++;
        if (tx_log.size() != exp_log.size()) begin
            n_fail++;
            $display("FAIL %s tx_bytes: got %0d bytes required %0d", tag, tx_log.size(), exp_log.size());
        end else begin
            for (int i = 0; i < exp_log.size(); i++) begin
                if (tx_log[i] !== exp_log[i]) begin
                    n_fail++;
                    $display("FAIL %s tx_byte%0d {pc,mar,mdr,we,byte}: got %h required %h",
                             tag, i, tx_log[i], exp_log[i]);
                    break;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", all_outs);
        end
`ifdef MEM_BUS_TIMEOUT_EN
        n_cmp++;
        if (bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bus_err: got %b required 0", bus_err);
        end
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fetch;
        ard_delay = 3;
        ref_mem[16'h1234] = 16'hBEEF;
        ard_mem[16'h1234] = 16'hBEEF;
        run_txn(1'b1, 1'b0, 16'h1234, 16'h0000, "fetch_1234");
    endtask

    task automatic test_store;
        run_txn(1'b0, 1'b1, 16'h00A0, 16'h5A3C, "store_00a0");
        run_txn(1'b0, 1'b0, 16'h00A0, 16'h0000, "load_00a0");
    endtask

    task automatic test_back_to_back;
        int k;
        ard_delay = 1;
        exp_mrdata = ref_rd(16'h0010);
        exp_fdata  = ref_rd(16'h2468);
        @(negedge clk);
        done_order.delete();
        tx_log.delete();
        fetch_req = 1'b1; fetch_addr = 16'h2468;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0010;
        k = 0;
        while (!mem_done && !fetch_done && k < 3000) begin @(negedge clk); k++; end
        mem_req = 1'b0;
        k = 0;
        while (!fetch_done && k < 3000) begin @(negedge clk); k++; end
        fetch_req = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (done_order.size() != 2 || done_order[0] !== 1'b0 || done_order[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL arb_order: got %0d pulses first_is_fetch=%b required mem then fetch",
                     done_order.size(), done_order.size() > 0 ? done_order[0] : 1'bx);
        end
        n_cmp++;
        if (mem_rdata !== exp_mrdata || fetch_data !== exp_fdata) begin
            n_fail++;
            $display("FAIL arb_data: got mem=%h fetch=%h required mem=%h fetch=%h",
                     mem_rdata, fetch_data, exp_mrdata, exp_fdata);
        end
        n_cmp++;
        if (tx_log.size() != 4 || tx_log[0] !== 12'h410 || tx_log[1] !== 12'h400
            || tx_log[2] !== 12'h868 || tx_log[3] !== 12'h824) begin
            n_fail++;
            $display("FAIL arb_bytes: got %0d bytes first=%h required 4 bytes 410,400,868,824",
                     tx_log.size(), tx_log.size() > 0 ? tx_log[0] : 12'hxxx);
        end
    endtask

    task automatic test_mid_reset;
        int k, md0;
        ard_delay = 2;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0C40; mem_wdata = 16'hA55A;
        k = 0;
        while (!(bus_mdr && bus_strobe) && k < 3000) begin @(negedge clk); k++; end
        md0 = n_mdone;
        #1 rst = 1'b0;
        #1;
        mem_req = 1'b0;
        n_cmp++;
        if (k >= 3000 || all_outs !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h (wait=%0d) required 0", all_outs, k);
        end
        repeat (12) @(negedge clk);
        rst = 1'b1;
        exp_fdata = '0; exp_mrdata = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (n_mdone != md0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got %0d pulses required 0", n_mdone - md0);
        end
        run_txn(1'b0, 1'b1, 16'h0C40, 16'hA55A, "store_after_reset");
        run_txn(1'b0, 1'b0, 16'h0C40, 16'h0000, "load_after_reset");
    endtask

    task automatic test_glitch;
        ard_delay = 2;
        glitch_held = 1'b0;
        glitch_arm = 1'b1;
        run_txn(1'b1, 1'b0, 16'h7E81, 16'h0000, "glitch_fetch");
        n_cmp++;
        if (glitch_held !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_hold: got advance=%b required no byte advance", !glitch_held);
        end
    endtask

    task automatic test_random;
        bit is_f, we;
        logic [15:0] a, wd;
        for (int i = 0; i < 24; i++) begin
            ard_delay = $urandom_range(0, 4);
            is_f = ($urandom_range(0, 2) == 0);
            we   = !is_f && $urandom_range(0, 1);
            a    = 16'h0100 + 16'($urandom_range(0, 7) * 2);
            wd   = 16'($urandom);
            run_txn(is_f, we, a, wd, $sformatf("rand%0d", i));
        end
    endtask

`ifdef MEM_BUS_TIMEOUT_EN
    task automatic test_timeout;
        int k, fd0;
        ard_en = 1'b0;
        fd0 = n_fdone;
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 16'h4321;
        k = 0;
        while (!busy && k < 20) begin @(negedge clk); k++; end
        repeat (TO - 1) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: got busy=%b after %0d cycles required 1", busy, TO);
        end
        @(negedge clk);
        fetch_req = 1'b0;
        n_cmp++;
        if ({busy, bus_err, bus_strobe, out_bus, bus_pc, bus_mar, bus_mdr} !== {1'b0, 1'b1, 1'b0, 8'h00, 3'b000}) begin
            n_fail++;
            $display("FAIL timeout_abort: got busy=%b err=%b strobe=%b out=%h required 0 1 0 00",
                     busy, bus_err, bus_strobe, out_bus);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (bus_err !== 1'b1 || busy !== 1'b0 || n_fdone != fd0) begin
            n_fail++;
            $display("FAIL timeout_sticky: got err=%b busy=%b dones=%0d required 1 0 0",
                     bus_err, busy, n_fdone - fd0);
        end
        ard_en = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: got err=%b required 0", bus_err);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_back_to_back();
        test_mid_reset();
        test_glitch();
        test_random();
`ifdef MEM_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Sequences all external-memory traffic for the 16-bit CPU core over the 8-bit Arduino bus. Arbitrates between the instruction-fetch requester and the load/store requester. Serialises each 16-bit address and write data as two bytes, low byte first. Gathers read data back the same way, using a 4-phase handshake on the Arduino ready lines. Sits between cpu_core and the chip pins (out_bus, in_bus, bus_pc, bus_mar, bus_mdr).

Parameters:
SYNC_STAGES, 2, flops in each synchroniser on ard_data_ready and ard_receive_ready (min 2)
TIMEOUT_CYCLES, 1023, handshake wait limit in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
fetch_req  in  1  instruction fetch request; level, held until fetch_done
fetch_addr  in  16  fetch address
mem_req  in  1  load/store request; level, held until mem_done
mem_we  in  1  1 = store, 0 = load
mem_addr  in  16  load/store address
mem_wdata  in  16  store data
ard_data_ready  in  1  Arduino presents a read byte on in_bus (asynchronous)
ard_receive_ready  in  1  Arduino has taken the byte on out_bus (asynchronous)
in_bus  in  8  read byte from Arduino
out_bus  out  8  byte to Arduino
bus_strobe  out  1  TX: byte valid; RX: byte accepted
bus_pc  out  1  address bytes belong to a fetch
bus_mar  out  1  address bytes belong to a load/store
bus_mdr  out  1  data-byte phase active
bus_we  out  1  current transaction is a store
fetch_done  out  1  1-cycle pulse; fetch_data valid
fetch_data  out  16  fetched word; held until next fetch completes
mem_done  out  1  1-cycle pulse; mem_rdata valid on loads
mem_rdata  out  16  loaded word; held until next load completes
busy  out  1  transaction in progress (state != IDLE)

Behaviour:
- Reset (rst low, any time, including mid-transaction):
  - state = IDLE; synchronisers cleared.
  - All outputs 0, including out_bus, fetch_data and mem_rdata.
  - An aborted transaction produces no done pulse.
- The controller uses only synchronised versions of ard_data_ready (rdy_rx) and ard_receive_ready (rdy_tx).
- States: IDLE, ADDR_LO, ADDR_HI, WDATA_LO, WDATA_HI, RDATA_LO, RDATA_HI, DONE.
  - Each byte state has sub-phase P0 (handshake rising) and P1 (handshake falling).
- IDLE arbitration:
  - mem_req wins over fetch_req.
  - On grant, latch addr, we, wdata and the requester id; go to ADDR_LO.
  - Requests are ignored when busy. Dropping a request mid-transaction does not abort it; the done pulse is still issued.
- TX byte state:
  - P0: out_bus = byte, bus_strobe = 1; wait for rdy_tx = 1.
  - P1: bus_strobe = 0, out_bus held; wait for rdy_tx = 0, then advance.
- RX byte state:
  - P0: wait for rdy_rx = 1, then capture in_bus.
  - P1: bus_strobe = 1; wait for rdy_rx = 0, then drop bus_strobe and advance.
- Transition paths:
  - Store: ADDR_LO -> ADDR_HI -> WDATA_LO -> WDATA_HI -> DONE.
  - Load/fetch: ADDR_LO -> ADDR_HI -> RDATA_LO -> RDATA_HI -> DONE.
- Byte order: ADDR_LO = addr[7:0]; ADDR_HI = addr[15:8]; data follows the same order.
- Flag outputs:
  - bus_pc = 1 during ADDR_* of a fetch.
  - bus_mar = 1 during ADDR_* of a load/store.
  - bus_mdr = 1 during WDATA_* and RDATA_*.
  - bus_we = 1 for the whole store transaction, IDLE excluded.
- DONE lasts 1 cycle:
  - Update fetch_data or mem_rdata (loads only) with the assembled word.
  - Pulse the matching done signal in the same cycle; return to IDLE.
  - Re-arbitration happens in the next cycle, so fetch is not starved between back-to-back loads.
- Any handshake wait may last indefinitely; there is no timeout unless the optional feature is compiled in.

Optional Feature:
Macro: MEM_BUS_TIMEOUT_EN.
- Enabled:
  - Adds output bus_err (1 bit).
  - A wait counter clears on every state or sub-phase change.
  - When the counter reaches TIMEOUT_CYCLES, the controller returns to IDLE, drives out_bus/bus_strobe/flags to 0 and sets bus_err.
  - bus_err is sticky until reset. No done pulse is issued for the aborted transaction.
- Disabled: no bus_err port, no counter logic; waits are unbounded.

Test Plan:
- Fetch read, fetch_addr=0x1234, Arduino model answers 0xBEEF with 3-cycle response delays -> out_bus sequence 0x34, 0x12 with bus_pc=1; fetch_data=0xBEEF; fetch_done pulses exactly once.
- Store, mem_we=1, mem_addr=0x00A0, mem_wdata=0x5A3C -> out_bus sequence 0xA0, 0x00, 0x3C, 0x5A; bus_mar=1 then bus_mdr=1; bus_we=1 throughout; mem_done pulses; mem_rdata unchanged.
- fetch_req and mem_req (load, 0x0010) raised in the same cycle -> load runs first; then fetch runs without dropping either req; two done pulses in that order.
- rst low during WDATA_LO -> all outputs 0 immediately; no mem_done; after release, a re-issued store completes correctly.
- ard_receive_ready glitch of 1 cycle shorter than the synchroniser path -> no byte advance; handshake still completes when the signal is held.
- With MEM_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=16, Arduino never asserts ready -> abort to IDLE after 16 cycles in ADDR_LO; bus_err=1 and stays 1; busy=0.
